// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the accumulator CPU: opcode encodings and the
// program-load FSM state type used by prog_mem_loadable.
package cpu_isa_pkg;

    localparam int opcode_size = 5;

    localparam logic [opcode_size-1:0] HLT  = 5'd0;
    localparam logic [opcode_size-1:0] STO  = 5'd1;
    localparam logic [opcode_size-1:0] LD_  = 5'd2;
    localparam logic [opcode_size-1:0] LDI  = 5'd3;
    localparam logic [opcode_size-1:0] ADD  = 5'd4;
    localparam logic [opcode_size-1:0] ADDI = 5'd5;
    localparam logic [opcode_size-1:0] SUB  = 5'd6;
    localparam logic [opcode_size-1:0] SUBI = 5'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/prog_mem_loadable_if.sv
// Fetch and load bus of the loadable program memory; the CPU/loader side is
// the master, the memory is the slave.
interface prog_mem_loadable_if #(
    parameter int addr_bus  = 11,
    parameter int data_size = 16
);
    logic                 Fetch_En;
    logic [addr_bus-1:0]  Fetch_Addr;
    logic [data_size-1:0] Data;
    logic                 Data_Valid;
    logic                 Load_Start;
    logic [7:0]           Load_Byte;
    logic                 Load_Byte_Valid;
    logic                 Load_Busy;
    logic                 Prog_Ready;
    logic                 Load_Err;
    logic [addr_bus:0]    Words_Loaded;
    logic                 Parity_Err;

    modport master (
        output Fetch_En, Fetch_Addr, Load_Start, Load_Byte, Load_Byte_Valid,
        input  Data, Data_Valid, Load_Busy, Prog_Ready, Load_Err, Words_Loaded, Parity_Err
    );

    modport slave (
        input  Fetch_En, Fetch_Addr, Load_Start, Load_Byte, Load_Byte_Valid,
        output Data, Data_Valid, Load_Busy, Prog_Ready, Load_Err, Words_Loaded, Parity_Err
    );
endinterface

// File: rtl/load_word_assembler.sv
// Collects a byte stream (most significant byte first) into instruction words;
// word_valid fires combinationally together with the final byte of each word.
module load_word_assembler #(
    parameter int data_size = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic [data_size-1:0] word,
    output logic                 word_valid
);
    localparam int bytes_per_word = data_size / 8;
    localparam int cnt_w = (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;

    logic [data_size-9:0] shreg;
    logic [cnt_w-1:0]     cnt;
    logic                 last_byte;

    assign last_byte  = (cnt == cnt_w'(bytes_per_word - 1));
    assign word       = {shreg, byte_in};
    assign word_valid = byte_valid && last_byte;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= word[data_size-9:0];
            cnt   <= last_byte ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/prog_mem_loadable.sv
// Writable program memory with registered fetch port and byte-stream loader.
// Define PROG_MEM_PARITY_EN to store an even-parity bit per word and flag fetch errors.
module prog_mem_loadable
    import cpu_isa_pkg::*;
#(
    parameter int addr_bus    = 11,
    parameter int data_size   = 16,
    parameter int opcode_size = cpu_isa_pkg::opcode_size
) (
    input  logic                Clk,
    input  logic                Reset,
    prog_mem_loadable_if.slave  bus
);
`ifdef PROG_MEM_PARITY_EN
    localparam int mem_w = data_size + 1;
`else
    localparam int mem_w = data_size;
`endif
    localparam int depth = 1 << addr_bus;

    logic [mem_w-1:0]     mem [depth];
    load_state_t          state, state_next;
    logic [addr_bus-1:0]  wr_addr;
    logic [addr_bus:0]    words;
    logic [data_size-1:0] data, word;
    logic                 data_valid, prog_ready, load_err;
    logic                 start_load, do_fetch, word_valid, is_hlt, last_addr;
    logic [mem_w-1:0]     rd_word, wr_word;

    load_word_assembler #(.data_size(data_size)) u_asm (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (start_load),
        .byte_in    (bus.Load_Byte),
        .byte_valid (bus.Load_Byte_Valid && (state == LOAD)),
        .word       (word),
        .word_valid (word_valid)
    );

    assign is_hlt    = (word[data_size-1 -: opcode_size] == opcode_size'(HLT));
    assign last_addr = (wr_addr == '1);
    assign rd_word   = mem[bus.Fetch_Addr];

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        do_fetch   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Load_Start) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end else if (bus.Fetch_En) begin
                    do_fetch = 1'b1;
                end
            end
            LOAD:    if (word_valid && (is_hlt || last_addr)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory is deliberately left out of reset; the write is masked while reset is asserted.
`ifdef PROG_MEM_PARITY_EN
    assign wr_word = {^word, word};
`else
    assign wr_word = word;
`endif

    always_ff @(posedge Clk) begin
        if (word_valid && Reset) mem[wr_addr] <= wr_word;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            wr_addr    <= '0;
            words      <= '0;
            prog_ready <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            data_valid <= do_fetch;
            if (do_fetch) data <= rd_word[data_size-1:0];
            if (start_load) begin
                wr_addr    <= '0;
                words      <= '0;
                prog_ready <= 1'b0;
                load_err   <= 1'b0;
            end
            if (word_valid) begin
                wr_addr <= wr_addr + 1'b1;
                words   <= words + 1'b1;
                if (is_hlt)         prog_ready <= 1'b1;
                else if (last_addr) load_err   <= 1'b1;
            end
        end
    end

`ifdef PROG_MEM_PARITY_EN
    logic parity_err;

    always_ff @(posedge Clk) begin
        if (!Reset) parity_err <= 1'b0;
        else        parity_err <= do_fetch && (^rd_word);
    end

    assign bus.Parity_Err = parity_err;
`else
    assign bus.Parity_Err = 1'b0;
`endif

    assign bus.Data         = data;
    assign bus.Data_Valid   = data_valid;
    assign bus.Load_Busy    = (state == LOAD);
    assign bus.Prog_Ready   = prog_ready;
    assign bus.Load_Err     = load_err;
    assign bus.Words_Loaded = words;
endmodule

// File: tb/tb_prog_mem_loadable.sv
// Directed bench for prog_mem_loadable: reset, program loads, fetch table,
// load/fetch arbitration, reset abort, overflow and (with PROG_MEM_PARITY_EN) parity.
module tb_prog_mem_loadable;
    import cpu_isa_pkg::*;

    localparam int AW    = 11;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } fetch_vec_t;

    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    fetch_vec_t    vecs [8];
    logic [DW-1:0] prog_a [8];

    prog_mem_loadable_if #(.addr_bus(AW), .data_size(DW)) bus ();

    prog_mem_loadable #(.addr_bus(AW), .data_size(DW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [AW-1:0] addr);
        bus.Fetch_En   = en;
        bus.Fetch_Addr = addr;
        step();
        bus.Fetch_En   = 1'b0;
    endtask

    task automatic start_load();
        bus.Load_Start = 1'b1;
        step();
        bus.Load_Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.Load_Byte       = b;
        bus.Load_Byte_Valid = 1'b1;
        step();
        bus.Load_Byte_Valid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic fetch_check(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        apply_stimulus(1'b1, addr);
        check_output({name, "_valid"}, 32'(bus.Data_Valid), 32'd1);
        check_output({name, "_data"}, 32'(bus.Data), 32'(exp));
    endtask

    initial begin
        prog_a[0] = {LDI, 11'd16};
        prog_a[1] = {STO, 11'd1};
        prog_a[2] = {ADD, 11'd3};
        prog_a[3] = {SUB, 11'd4};
        prog_a[4] = 16'h4005;
        prog_a[5] = 16'h5006;
        prog_a[6] = 16'h6007;
        prog_a[7] = {HLT, 11'd0};

        vecs[0] = '{1'b1, 11'd5, 1'b1, 16'h5006};
        vecs[1] = '{1'b0, 11'd0, 1'b0, 16'h5006};
        vecs[2] = '{1'b1, 11'd0, 1'b1, 16'h1810};
        vecs[3] = '{1'b1, 11'd1, 1'b1, 16'h0801};
        vecs[4] = '{1'b1, 11'd7, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 11'd2, 1'b1, 16'h2003};
        vecs[6] = '{1'b0, 11'd3, 1'b0, 16'h2003};
        vecs[7] = '{1'b1, 11'd6, 1'b1, 16'h6007};

        Reset               = 1'b0;
        bus.Fetch_En        = 1'b0;
        bus.Fetch_Addr      = '0;
        bus.Load_Start      = 1'b0;
        bus.Load_Byte       = '0;
        bus.Load_Byte_Valid = 1'b0;
        step();
        step();

        check_output("rst_data", 32'(bus.Data), 32'h0);
        check_output("rst_valid", 32'(bus.Data_Valid), 32'h0);
        check_output("rst_busy", 32'(bus.Load_Busy), 32'h0);
        check_output("rst_ready", 32'(bus.Prog_Ready), 32'h0);
        check_output("rst_err", 32'(bus.Load_Err), 32'h0);
        check_output("rst_words", 32'(bus.Words_Loaded), 32'h0);
        check_output("rst_parity", 32'(bus.Parity_Err), 32'h0);
        Reset = 1'b1;
        step();

        // Eight-word program ending in HLT, then reset must keep the memory contents.
        start_load();
        check_output("a_busy", 32'(bus.Load_Busy), 32'h1);
        check_output("a_words0", 32'(bus.Words_Loaded), 32'h0);
        for (int i = 0; i < 8; i++) send_word(prog_a[i]);
        check_output("a_words", 32'(bus.Words_Loaded), 32'd8);
        check_output("a_ready", 32'(bus.Prog_Ready), 32'h1);
        check_output("a_done_busy", 32'(bus.Load_Busy), 32'h0);
        Reset = 1'b0;
        step();
        check_output("rst2_ready", 32'(bus.Prog_Ready), 32'h0);
        check_output("rst2_words", 32'(bus.Words_Loaded), 32'h0);
        Reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].addr);
            check_output($sformatf("vec%0d_valid", i), 32'(bus.Data_Valid), 32'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d_data", i), 32'(bus.Data), 32'(vecs[i].exp_data));
            check_output($sformatf("vec%0d_parity", i), 32'(bus.Parity_Err), 32'h0);
        end

        // Three-word program overwrites words 0..2 only.
        start_load();
        send_word(16'h1810);
        send_word(16'h0801);
        send_word(16'h0000);
        check_output("b_words", 32'(bus.Words_Loaded), 32'd3);
        check_output("b_ready", 32'(bus.Prog_Ready), 32'h1);
        step();
        fetch_check("b_f0", 11'd0, 16'h1810);
        fetch_check("b_f1", 11'd1, 16'h0801);
        fetch_check("b_f2", 11'd2, 16'h0000);
        fetch_check("b_f3", 11'd3, 16'h3004);

        // Load_Start together with Fetch_En: load wins, fetch and restart ignored while loading.
        bus.Load_Start = 1'b1;
        bus.Fetch_En   = 1'b1;
        bus.Fetch_Addr = 11'd1;
        step();
        bus.Load_Start = 1'b0;
        check_output("c_start_valid", 32'(bus.Data_Valid), 32'h0);
        check_output("c_start_data", 32'(bus.Data), 32'h3004);
        check_output("c_start_busy", 32'(bus.Load_Busy), 32'h1);
        check_output("c_start_ready", 32'(bus.Prog_Ready), 32'h0);
        step();
        check_output("c_load_valid", 32'(bus.Data_Valid), 32'h0);
        bus.Fetch_En = 1'b0;
        send_byte(8'h28);
        bus.Load_Start = 1'b1;
        step();
        bus.Load_Start = 1'b0;
        check_output("c_restart_busy", 32'(bus.Load_Busy), 32'h1);
        send_byte(8'h01);
        check_output("c_words1", 32'(bus.Words_Loaded), 32'd1);
        send_word({HLT, 11'd0});
        check_output("c_words2", 32'(bus.Words_Loaded), 32'd2);
        step();
        check_output("c_ready_hold", 32'(bus.Prog_Ready), 32'h1);
        fetch_check("c_f0", 11'd0, 16'h2801);

        // Reset after the third byte of a load aborts it; the partial word is dropped.
        start_load();
        send_word(16'h4005);
        send_byte(8'h11);
        Reset = 1'b0;
        step();
        check_output("d_busy", 32'(bus.Load_Busy), 32'h0);
        check_output("d_ready", 32'(bus.Prog_Ready), 32'h0);
        Reset = 1'b1;
        step();
        fetch_check("d_f0", 11'd0, 16'h4005);
        fetch_check("d_f1", 11'd1, 16'h0000);

        // Fill the whole memory without an HLT.
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            send_word({ADD, 11'd1});
            if (i == DEPTH - 2) begin
                check_output("e_busy_penult", 32'(bus.Load_Busy), 32'h1);
                check_output("e_words_penult", 32'(bus.Words_Loaded), 32'(DEPTH - 1));
            end
        end
        check_output("e_busy", 32'(bus.Load_Busy), 32'h0);
        check_output("e_err", 32'(bus.Load_Err), 32'h1);
        check_output("e_ready", 32'(bus.Prog_Ready), 32'h0);
        check_output("e_words", 32'(bus.Words_Loaded), 32'(DEPTH));
        step();
        check_output("e_err_hold", 32'(bus.Load_Err), 32'h1);
        fetch_check("e_flast", 11'(DEPTH - 1), 16'h2001);
        fetch_check("e_f0", 11'd0, 16'h2001);

`ifdef PROG_MEM_PARITY_EN
        dut.mem[10] = 17'h00001;
        fetch_check("p_bad", 11'd10, 16'h0001);
        check_output("p_bad_flag", 32'(bus.Parity_Err), 32'h1);
        fetch_check("p_good", 11'd11, 16'h2001);
        check_output("p_good_flag", 32'(bus.Parity_Err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
